// File: rtl/lut_sxx_frac_cfgchain.sv
// S_XX fracturable LUT pair: two chained K-input sub-LUTs with a split bit, loaded
// through a beat-serial shadow register and committed atomically, with daisy-chain pass-through.
module lut_sxx_frac_sub #(
   parameter int K = 4,
   parameter int F = 2
) (
   input  logic [2**K-1:0]     mem,
   input  logic [K-1:0]        a,
   output logic [2**(F-1)-1:0] slices,
   output logic                full
);
   localparam int SUB = 2**(F-1);
   localparam int SW  = K - F + 1;

   assign full = mem[a];

   // Slice i reads window i of the memory, addressed by the low SW address bits.
   for (genvar i = 0; i < SUB; i++) begin : g_slice
      logic [K-1:0] idx;
      assign idx       = K'(i * (2**SW)) | K'(a[SW-1:0]);
      assign slices[i] = mem[idx];
   end
endmodule

module lut_sxx_frac_cfgchain #(
   parameter int INPUTS     = 4,
   parameter int FRACTURING = 2,
   parameter int CFG_W      = 8
) (
   input  logic                              cclk,
   input  logic                              crst_n,
   input  logic [2*INPUTS-1:0]               addr,
   output logic [2*(2**(FRACTURING-1))+1:0]  out,
   input  logic                              cen,
   input  logic [CFG_W-1:0]                  cfg_data,
   input  logic                              cfg_rearm,
   output logic [CFG_W-1:0]                  cfg_dout,
   output logic                              cfg_dout_valid,
   output logic                              cfg_done,
   output logic                              cfg_loaded
);
   localparam int K        = INPUTS;
   localparam int MEM      = 2**K;
   localparam int SUB      = 2**(FRACTURING-1);
   localparam int CFG_BITS = 2*MEM + 1;
   localparam int BEATS    = (CFG_BITS + CFG_W - 1) / CFG_W;
   localparam int BC_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {S_LOAD, S_COMMIT, S_PASS} state_t;

   state_t              state, state_nxt;
   logic [BC_W-1:0]     bc;
   // Only the low CFG_BITS of the shadow can ever reach the active memory; pad bits fall off the top.
   logic [CFG_BITS-1:0] shadow;
   logic [CFG_BITS-1:0] act;
   logic                last_beat;

   assign last_beat = (state == S_LOAD) && cen && (bc == BC_W'(BEATS-1));

   always_ff @(posedge cclk) begin
      if (!crst_n) state <= S_LOAD;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cfg_done  = 1'b0;
      case (state)
         S_LOAD:   if (last_beat) state_nxt = S_COMMIT;
         S_COMMIT: begin
            cfg_done  = crst_n && !cfg_rearm;
            state_nxt = S_PASS;
         end
         S_PASS:   state_nxt = S_PASS;
         default:  state_nxt = S_LOAD;
      endcase
      if (cfg_rearm) state_nxt = S_LOAD;
   end

   always_ff @(posedge cclk) begin
      if (!crst_n) begin
         bc             <= '0;
         shadow         <= '0;
         act            <= '0;
         cfg_dout       <= '0;
         cfg_dout_valid <= 1'b0;
         cfg_loaded     <= 1'b0;
      end else if (cfg_rearm) begin
         bc             <= '0;
         cfg_dout_valid <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               cfg_dout_valid <= 1'b0;
               if (cen) begin
                  shadow <= CFG_BITS'({shadow, cfg_data});
                  bc     <= last_beat ? '0 : bc + BC_W'(1);
               end
            end
            default: begin
               if (state == S_COMMIT) begin
                  act        <= shadow;
                  cfg_loaded <= 1'b1;
               end
               cfg_dout_valid <= cen;
               if (cen) cfg_dout <= cfg_data;
            end
         endcase
      end
   end

   // Active layout {sp, lower_mem, upper_mem}.
   logic           sp;
   logic [MEM-1:0] lower_mem, upper_mem;
   logic [K-1:0]   lower_a, upper_a;
   logic [SUB-1:0] lower_sl, upper_sl;
   logic           lower_full, upper_full;

   assign sp        = act[2*MEM];
   assign lower_mem = act[2*MEM-1:MEM];
   assign upper_mem = act[MEM-1:0];
   assign lower_a   = addr[2*K-1:K];
   // With sp clear the upper sub-LUT's top input is fed by the lower full output (chaining).
   assign upper_a   = {sp ? addr[K-1] : lower_full, addr[K-2:0]};

   lut_sxx_frac_sub #(.K(K), .F(FRACTURING)) u_sub[1:0] (
      .mem    ({upper_mem,  lower_mem}),
      .a      ({upper_a,    lower_a}),
      .slices ({upper_sl,   lower_sl}),
      .full   ({upper_full, lower_full})
   );

   assign out = {upper_full, lower_full, upper_sl, lower_sl};
endmodule

// File: tb/tb_lut_sxx_frac_cfgchain.sv
// Randomized and directed checks of the fracturable LUT pair against a config-level model.
module tb_lut_sxx_frac_cfgchain;
   logic       cclk = 1'b0;
   logic       crst_n, cen, cfg_rearm;
   logic [7:0] addr, cfg_data;
   logic [5:0] out;
   logic [7:0] cfg_dout;
   logic       cfg_dout_valid, cfg_done, cfg_loaded;

   int vectors = 0;
   int miscompares = 0;

   lut_sxx_frac_cfgchain #(.INPUTS(4), .FRACTURING(2), .CFG_W(8)) dut (
      .cclk(cclk), .crst_n(crst_n), .addr(addr), .out(out), .cen(cen),
      .cfg_data(cfg_data), .cfg_rearm(cfg_rearm), .cfg_dout(cfg_dout),
      .cfg_dout_valid(cfg_dout_valid), .cfg_done(cfg_done), .cfg_loaded(cfg_loaded)
   );

   always #5 cclk = ~cclk;

   // Model: beats collected since arm, phase 0=loading 1=committing 2=passing.
   logic [39:0] m_sh;
   int          m_cnt, m_ph;
   logic        m_sp, m_ld, m_dv;
   logic [15:0] m_lo, m_up;
   logic [7:0]  m_dout;

   function automatic logic [5:0] ref_out(logic [7:0] ad);
      int la, ua, lf, uf, ls0, ls1, us0, us1;
      la  = int'(ad[7:4]);
      lf  = (int'(m_lo) >> la) & 1;
      ls0 = (int'(m_lo) >> (la % 8)) & 1;
      ls1 = (int'(m_lo) >> (8 + la % 8)) & 1;
      ua  = m_sp ? int'(ad[3:0]) : lf * 8 + int'(ad[2:0]);
      uf  = (int'(m_up) >> ua) & 1;
      us0 = (int'(m_up) >> (ua % 8)) & 1;
      us1 = (int'(m_up) >> (8 + ua % 8)) & 1;
      return {uf[0], lf[0], us1[0], us0[0], ls1[0], ls0[0]};
   endfunction

   function automatic logic ref_done();
      return (m_ph == 1) && !cfg_rearm && crst_n;
   endfunction

   task automatic set_in(input logic c, input logic [7:0] d, input logic r,
                         input logic rs, input logic [7:0] a);
      cen = c; cfg_data = d; cfg_rearm = r; crst_n = rs; addr = a;
      @(negedge cclk);
   endtask

   task automatic tick();
      @(posedge cclk);
      if (!crst_n) begin
         m_sh = '0; m_cnt = 0; m_ph = 0; m_sp = 0; m_lo = '0; m_up = '0;
         m_ld = 0; m_dv = 0; m_dout = '0;
      end else if (cfg_rearm) begin
         m_cnt = 0; m_ph = 0; m_dv = 0;
      end else if (m_ph == 0) begin
         m_dv = 0;
         if (cen) begin
            m_sh = {m_sh[31:0], cfg_data};
            m_cnt++;
            if (m_cnt == 5) begin m_cnt = 0; m_ph = 1; end
         end
      end else begin
         if (m_ph == 1) begin
            m_sp = m_sh[32]; m_lo = m_sh[31:16]; m_up = m_sh[15:0]; m_ld = 1;
         end
         m_ph = 2;
         m_dv = cen;
         if (cen) m_dout = cfg_data;
      end
      #1;
   endtask

   task automatic send_cfg(input logic [7:0] b0, input logic [15:0] lo, input logic [15:0] up);
      logic [7:0] bs [5];
      bs[0] = b0; bs[1] = lo[15:8]; bs[2] = lo[7:0]; bs[3] = up[15:8]; bs[4] = up[7:0];
      for (int i = 0; i < 5; i++) begin set_in(1, bs[i], 0, 1, 8'h00); tick(); end
   endtask

   task automatic test_reset();
      set_in(0, 8'h00, 0, 0, 8'h00); tick();
      set_in(0, 8'h00, 0, 0, 8'h00); tick();
      for (int i = 0; i < 6; i++) begin
         set_in(0, 8'h00, 0, 1, 8'($urandom));
         vectors++;
         if (out !== 6'd0 || cfg_loaded !== 1'b0 || cfg_done !== 1'b0 || cfg_dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: out=%h loaded=%b done=%b dv=%b, required out=0 loaded=0 done=0 dv=0",
                     out, cfg_loaded, cfg_done, cfg_dout_valid);
         end
         tick();
      end
   endtask

   task automatic test_load_split();
      send_cfg(8'h01, 16'h8000, 16'h0101);
      set_in(0, 8'h00, 0, 1, 8'hF0);
      vectors++;
      if (cfg_done !== 1'b1) begin
         miscompares++; $display("FAIL split_done_pulse: cfg_done=%b required 1", cfg_done);
      end
      tick();
      set_in(0, 8'h00, 0, 1, 8'hF0);
      vectors++;
      if (cfg_done !== 1'b0 || cfg_loaded !== 1'b1) begin
         miscompares++; $display("FAIL split_done_once: done=%b loaded=%b required 0/1", cfg_done, cfg_loaded);
      end
      vectors++;
      if (out[5] !== 1'b1 || out[4] !== 1'b1 || out[1:0] !== 2'b10) begin
         miscompares++; $display("FAIL split_F0: out=%b required uf=1 lf=1 lower slices=10", out);
      end
      set_in(0, 8'h00, 0, 1, 8'hF1);
      vectors++;
      if (out[5] !== 1'b0 || out !== ref_out(8'hF1)) begin
         miscompares++; $display("FAIL split_F1: out=%b required %b", out, ref_out(8'hF1));
      end
      tick();
   endtask

   task automatic test_load_chain();
      set_in(0, 8'h00, 1, 1, 8'h00); tick();
      send_cfg(8'h00, 16'h8000, 16'h0101);
      set_in(0, 8'h00, 0, 1, 8'h00); tick();
      set_in(0, 8'h00, 0, 1, 8'hF0);
      vectors++;
      if (out[5] !== 1'b1 || out !== ref_out(8'hF0)) begin
         miscompares++; $display("FAIL chain_F0: out=%b required %b (upper_full 1)", out, ref_out(8'hF0));
      end
      for (int i = 0; i < 8; i++) begin
         set_in(0, 8'h00, 0, 1, 8'($urandom));
         vectors++;
         if (out !== ref_out(addr)) begin
            miscompares++; $display("FAIL chain_addr %h: out=%b required %b", addr, out, ref_out(addr));
         end
      end
      tick();
   endtask

   task automatic test_pass_through();
      logic [5:0] held;
      logic [7:0] bs [5];
      logic       cs [5];
      bs = '{8'hA5, 8'h00, 8'h3C, 8'h00, 8'h00};
      cs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      set_in(0, 8'h00, 0, 1, 8'h5A);
      held = ref_out(8'h5A);
      tick();
      for (int i = 0; i < 5; i++) begin
         set_in(cs[i], bs[i], 0, 1, 8'h5A);
         vectors++;
         if (i > 0 && (cfg_dout_valid !== cs[i-1] || (cs[i-1] && cfg_dout !== bs[i-1]))) begin
            miscompares++;
            $display("FAIL pass_beat%0d: dv=%b dout=%h required dv=%b dout=%h",
                     i, cfg_dout_valid, cfg_dout, cs[i-1], bs[i-1]);
         end
         vectors++;
         if (out !== held) begin
            miscompares++; $display("FAIL pass_out_stable: out=%b required %b", out, held);
         end
         tick();
      end
   endtask

   task automatic test_rearm();
      int dones = 0;
      logic [7:0] bs [5];
      set_in(0, 8'h00, 1, 1, 8'h00); tick();
      for (int i = 0; i < 3; i++) begin set_in(1, 8'($urandom), 0, 1, 8'($urandom)); tick(); end
      set_in(1, 8'hFF, 1, 1, 8'h00); tick();
      bs = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      for (int i = 0; i < 9; i++) begin
         set_in(i < 5, (i < 5) ? bs[i] : 8'h00, 0, 1, 8'($urandom));
         if (cfg_done === 1'b1) dones++;
         vectors++;
         if (out !== ref_out(addr) || cfg_done !== ref_done()) begin
            miscompares++; $display("FAIL rearm_cycle%0d: out=%b done=%b required %b %b",
                                    i, out, cfg_done, ref_out(addr), ref_done());
         end
         tick();
      end
      vectors++;
      if (dones != 1 || m_lo !== 16'h1234 || m_up !== 16'h5678 || m_sp !== 1'b1) begin
         miscompares++; $display("FAIL rearm_single_commit: done pulses=%0d required 1", dones);
      end
   endtask

   task automatic test_reset_midload();
      int dones = 0;
      set_in(0, 8'h00, 1, 1, 8'h00); tick();
      set_in(1, 8'h01, 0, 1, 8'h00); tick();
      set_in(1, 8'hFF, 0, 1, 8'h00); tick();
      set_in(1, 8'hFF, 0, 0, 8'h00); tick();
      for (int i = 0; i < 4; i++) begin
         set_in(i < 2, 8'hFF, 0, 1, 8'($urandom));
         if (cfg_done === 1'b1) dones++;
         vectors++;
         if (out !== 6'd0 || cfg_loaded !== 1'b0) begin
            miscompares++; $display("FAIL rst_midload: out=%b loaded=%b required 0 0", out, cfg_loaded);
         end
         tick();
      end
      vectors++;
      if (dones != 0) begin
         miscompares++; $display("FAIL rst_no_done: pulses=%0d required 0", dones);
      end
      set_in(0, 8'h00, 1, 1, 8'h00); tick();
      send_cfg(8'h00, 16'hC3A5, 16'h0F0F);
      set_in(0, 8'h00, 0, 1, 8'h00);
      vectors++;
      if (cfg_done !== 1'b1) begin
         miscompares++; $display("FAIL rst_reload_done: cfg_done=%b required 1", cfg_done);
      end
      tick();
      for (int i = 0; i < 6; i++) begin
         set_in(0, 8'h00, 0, 1, 8'($urandom));
         vectors++;
         if (out !== ref_out(addr) || cfg_loaded !== 1'b1) begin
            miscompares++; $display("FAIL rst_reload_out: out=%b loaded=%b required %b 1",
                                    out, cfg_loaded, ref_out(addr));
         end
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 24) == 0,
                $urandom_range(0, 59) != 0, 8'($urandom));
         vectors++;
         if (out !== ref_out(addr) || cfg_done !== ref_done() || cfg_loaded !== m_ld ||
             cfg_dout_valid !== m_dv || (m_dv && cfg_dout !== m_dout)) begin
            miscompares++;
            $display("FAIL random%0d: out=%b done=%b ld=%b dv=%b dout=%h required %b %b %b %b %h",
                     i, out, cfg_done, cfg_loaded, cfg_dout_valid, cfg_dout,
                     ref_out(addr), ref_done(), m_ld, m_dv, m_dout);
         end
         tick();
      end
   endtask

   initial begin
      cen = 0; cfg_data = '0; cfg_rearm = 0; crst_n = 0; addr = '0;
      m_sh = '0; m_cnt = 0; m_ph = 0; m_sp = 0; m_lo = '0; m_up = '0;
      m_ld = 0; m_dv = 0; m_dout = '0;
      @(posedge cclk); #1;
      test_reset();
      test_load_split();
      test_load_chain();
      test_pass_through();
      test_rearm();
      test_reset_midload();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
